// File: rtl/serial_addsub.sv
// -----------------------------------------------------------------------------
// serial_addsub
//   Bit-serial adder/subtractor: one full-adder cell plus a carry flip-flop
//   computes a WIDTH-bit sum or difference one bit per clock, LSB first,
//   behind a start/done handshake.
//
//   Subtraction is formed as a + ~b + 1: operand B is inverted on load and
//   the carry flip-flop is preset to 1.
//
// Parameters
//   WIDTH   operand/result width in bits (>= 2)
//
// Ports
//   clk     in   rising-edge clock
//   rst_n   in   asynchronous active-low reset
//   start   in   request a new operation (sampled only in IDLE)
//   sub     in   0 = a+b, 1 = a-b (sampled with start)
//   a, b    in   operands (sampled with start)
//   busy    out  high in RUN and DONE
//   done    out  one-cycle pulse when result/cout/ovf become valid
//   result  out  sum or difference modulo 2^WIDTH
//   cout    out  final carry; in subtract mode 1 means no borrow
//   ovf     out  signed overflow flag
//
// Configuration
//   SERIAL_ADDSUB_OVF_EN  when defined, ovf tracks the carry into the MSB and
//                         reports carry-in ^ carry-out of the MSB; when
//                         undefined, ovf is constant 0.
// -----------------------------------------------------------------------------
module serial_addsub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf
);

    localparam int             CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_r;
    logic [WIDTH-1:0] sa_r;
    logic [WIDTH-1:0] sb_r;
    logic             c_r;
    logic [CW-1:0]    cnt_r;
    logic             sum_s;
    logic             cnext_s;

    // Carry-out of a full adder is the majority of its three inputs.
    function automatic logic maj3(input logic x, input logic y, input logic z);
        return (x & y) | (x & z) | (y & z);
    endfunction

    // Single full-adder cell working on the current LSBs and the carry.
    assign sum_s   = sa_r[0] ^ sb_r[0] ^ c_r;
    assign cnext_s = maj3(sa_r[0], sb_r[0], c_r);

`ifdef SERIAL_ADDSUB_OVF_EN
    logic ovf_r;
    assign ovf = ovf_r;

    // Overflow flag: carry into the MSB xor carry out of the MSB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_r <= 1'b0;
        end else if ((state_r == S_RUN) && (cnt_r == LAST)) begin
            ovf_r <= c_r ^ cnext_s;
        end else begin
            ovf_r <= ovf_r;
        end
    end
`else
    assign ovf = 1'b0;
`endif

    // Control FSM, operand shifters, carry, counter and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
            sa_r    <= '0;
            sb_r    <= '0;
            c_r     <= 1'b0;
            cnt_r   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            result  <= '0;
            cout    <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        sa_r    <= a;
                        sb_r    <= b ^ {WIDTH{sub}};
                        c_r     <= sub;
                        cnt_r   <= '0;
                        busy    <= 1'b1;
                        state_r <= S_RUN;
                    end else begin
                        busy    <= 1'b0;
                    end
                end
                S_RUN: begin
                    result <= {sum_s, result[WIDTH-1:1]};
                    sa_r   <= {1'b0, sa_r[WIDTH-1:1]};
                    sb_r   <= {1'b0, sb_r[WIDTH-1:1]};
                    c_r    <= cnext_s;
                    if (cnt_r == LAST) begin
                        // MSB processed this cycle: publish carry and finish.
                        cout    <= cnext_s;
                        done    <= 1'b1;
                        state_r <= S_DONE;
                    end else begin
                        cnt_r   <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
                    end
                end
                S_DONE: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    state_r <= S_IDLE;
                end
                default: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_addsub.sv
// -----------------------------------------------------------------------------
// tb_serial_addsub
//   Self-checking bench for serial_addsub (WIDTH=8). Directed cases from the
//   feature list plus randomized operands, all compared against an arithmetic
//   reference model. Expected ovf follows SERIAL_ADDSUB_OVF_EN.
// -----------------------------------------------------------------------------
module tb_serial_addsub;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         cout;
    logic         ovf;

    int checks   = 0;
    int failures = 0;

    serial_addsub #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .sub    (sub),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .cout   (cout),
        .ovf    (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic. Returns {ovf, cout, result}.
    function automatic logic [W+1:0] ref_op(input logic [W-1:0] x, input logic [W-1:0] y,
                                            input logic s);
        int          ix;
        int          iy;
        int          sr;
        logic [31:0] ur;
        logic        c;
        logic        v;
        ix = int'($signed(x));
        iy = int'($signed(y));
        ur = s ? (int'(x) - int'(y)) : (int'(x) + int'(y));
        c  = s ? (x >= y) : (ur > 32'd255);
        sr = s ? (ix - iy) : (ix + iy);
`ifdef SERIAL_ADDSUB_OVF_EN
        v  = (sr > 127) || (sr < -128);
`else
        v  = 1'b0;
`endif
        return {v, c, ur[W-1:0]};
    endfunction

    task automatic check_outputs(input string tag, input logic [W-1:0] x,
                                 input logic [W-1:0] y, input logic s);
        logic [W+1:0] e;
        e = ref_op(x, y, s);
        check_eq({tag, "_result"}, 32'(result), 32'(e[W-1:0]));
        check_eq({tag, "_cout"},   32'(cout),   32'(e[W]));
        check_eq({tag, "_ovf"},    32'(ovf),    32'(e[W+1]));
    endtask

    // One complete operation; latency counts edges from the accepting edge
    // (counted as 1) through the edge after which done is visible.
    task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic s, input string tag);
        int lat;
        @(negedge clk);
        a = x; b = y; sub = s; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1;
        check_eq({tag, "_busy"}, 32'(busy), 32'd1);
        while (!done && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check_eq({tag, "_latency"}, 32'(lat), 32'd9);
        check_outputs(tag, x, y, s);
        @(posedge clk); #1;
        check_eq({tag, "_done_width"}, 32'(done), 32'd0);
        check_eq({tag, "_busy_end"},   32'(busy), 32'd0);
    endtask

    initial begin
        int           lat;
        logic [W-1:0] ha;
        logic [W-1:0] hb;
        logic         hs;

        rst_n = 1'b0; start = 1'b0; sub = 1'b0; a = '0; b = '0;
        #12;
        check_eq("reset_busy",   32'(busy),   32'd0);
        check_eq("reset_done",   32'(done),   32'd0);
        check_eq("reset_result", 32'(result), 32'd0);
        check_eq("reset_cout",   32'(cout),   32'd0);
        check_eq("reset_ovf",    32'(ovf),    32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed cases
        run_op(8'd100,  8'd55,  1'b0, "add_nocarry");
        run_op(8'd200,  8'd100, 1'b0, "add_carry");
        run_op(8'd5,    8'd3,   1'b1, "sub_noborrow");
        run_op(8'd3,    8'd5,   1'b1, "sub_borrow");
        run_op(8'h7F,   8'h01,  1'b0, "ovf_add");
        run_op(8'h80,   8'h01,  1'b1, "ovf_sub");
        run_op(8'hFF,   8'hFF,  1'b0, "add_max");
        run_op(8'h00,   8'h00,  1'b1, "sub_zero");

        // A second start during RUN must be ignored
        @(negedge clk);
        a = 8'd17; b = 8'd9; sub = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        a = 8'd250; b = 8'd77; sub = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 4;
        while (!done && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check_eq("ignore_latency", 32'(lat), 32'd9);
        check_outputs("ignore", 8'd17, 8'd9, 1'b0);
        @(posedge clk); #1;
        check_eq("ignore_done_width", 32'(done), 32'd0);

        // start held high: accept every 10 cycles, new operands each time
        @(negedge clk);
        ha = W'($urandom); hb = W'($urandom); hs = 1'($urandom);
        a = ha; b = hb; sub = hs; start = 1'b1;
        for (int k = 0; k < 50; k++) begin
            @(posedge clk); #1;
            check_eq("hold_done", 32'(done), 32'((k % 10) == 8));
            if (done) begin
                check_outputs("hold", ha, hb, hs);
                ha = W'($urandom); hb = W'($urandom); hs = 1'($urandom);
                a = ha; b = hb; sub = hs;
            end
        end
        start = 1'b0;
        @(posedge clk); #1;
        check_eq("hold_idle_busy", 32'(busy), 32'd0);

        // Asynchronous reset four cycles into RUN
        @(negedge clk);
        a = 8'd123; b = 8'd45; sub = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("rst_busy",   32'(busy),   32'd0);
        check_eq("rst_done",   32'(done),   32'd0);
        check_eq("rst_result", 32'(result), 32'd0);
        check_eq("rst_cout",   32'(cout),   32'd0);
        check_eq("rst_ovf",    32'(ovf),    32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            check_eq("rst_no_done", 32'(done), 32'd0);
        end
        run_op(8'd1, 8'd1, 1'b0, "after_reset");

        // Randomized operations
        for (int i = 0; i < 20; i++) begin
            run_op(W'($urandom), W'($urandom), 1'($urandom), "random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
